// File: rtl/byte_ram_pkg.sv
// Shared types and width helpers for the byte-access SRAM controller.
// The replicate helper returns a maximally wide word; callers size-cast it.
package byte_ram_pkg;

  localparam int MAX_BPW = 16;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_RD_HOLD
  } state_e;

  function automatic int calc_lane_w(input int bpw);
    return $clog2(bpw);
  endfunction

  function automatic int calc_waddr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int calc_addr_w(input int bpw, input int depth);
    return $clog2(depth) + $clog2(bpw);
  endfunction

  function automatic logic [8*MAX_BPW-1:0] replicate_byte(input logic [7:0] b);
    return {MAX_BPW{b}};
  endfunction

endpackage

// File: rtl/byte_ram_ctrl_if.sv
// Host-side command and response channels of the byte RAM controller.
interface byte_ram_ctrl_if #(
  parameter int ADDR_W = 7,
  parameter int LEN_W  = 4
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cmd_wdata;
  logic [LEN_W-1:0]  cmd_len;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [7:0]        rsp_data;
  logic              rsp_last;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_len, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_last
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_len, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_last
  );
endinterface

// File: rtl/byte_lane_mux.sv
// Picks one 8-bit lane out of a RAM word using a registered lane index.
module byte_lane_mux
  import byte_ram_pkg::*;
#(
  parameter  int BYTES_PER_WORD = 4,
  localparam int LANE_W         = calc_lane_w(BYTES_PER_WORD)
) (
  input  logic [8*BYTES_PER_WORD-1:0] word_i,
  input  logic [LANE_W-1:0]           lane_i,
  output logic [7:0]                  byte_o
);

  always_comb begin
    byte_o = '0;
    for (int l = 0; l < BYTES_PER_WORD; l++) begin
      if (lane_i == LANE_W'(l)) byte_o = word_i[8*l +: 8];
    end
  end

endmodule

// File: rtl/byte_ram_ctrl.sv
// Byte write / burst read controller for a word-wide synchronous SRAM.
// Define CLEAR_ON_RESET_EN to zero the whole array after reset before serving the host.
//
// state       | meaning
// ST_CLEAR    | post-reset zero sweep, one word per cycle
// ST_IDLE     | accepting commands; writes complete here
// ST_RD_ISSUE | RAM read enable on the port for the current word
// ST_RD_WAIT  | RAM data arriving, lane captured into rsp_data
// ST_RD_HOLD  | response held until the host takes it
module byte_ram_ctrl
  import byte_ram_pkg::*;
#(
  parameter  int BYTES_PER_WORD = 4,
  parameter  int DEPTH          = 32,
  parameter  int LEN_W          = 4,
  localparam int LANE_W         = calc_lane_w(BYTES_PER_WORD),
  localparam int WADDR_W        = calc_waddr_w(DEPTH),
  localparam int ADDR_W         = calc_addr_w(BYTES_PER_WORD, DEPTH),
  localparam int DI_W           = 8*BYTES_PER_WORD
) (
  input  logic                      clk,
  input  logic                      rst_n,
  byte_ram_ctrl_if.slave            host,
  output logic                      busy,
  output logic                      ram_en,
  output logic [WADDR_W-1:0]        ram_addr,
  output logic [BYTES_PER_WORD-1:0] ram_we,
  output logic [DI_W-1:0]           ram_di,
  input  logic [DI_W-1:0]           ram_do
);

`ifdef CLEAR_ON_RESET_EN
  localparam state_e RESET_STATE = ST_CLEAR;
  logic [WADDR_W-1:0] clr_q, clr_d;
`else
  localparam state_e RESET_STATE = ST_IDLE;
`endif

  state_e                    state_q, state_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic [LEN_W-1:0]          cnt_q, cnt_d;
  logic                      cmd_ready_q, cmd_ready_d;
  logic                      busy_q, busy_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [7:0]                rsp_data_q, rsp_data_d;
  logic                      rsp_last_q, rsp_last_d;
  logic                      ram_en_q, ram_en_d;
  logic [WADDR_W-1:0]        ram_addr_q, ram_addr_d;
  logic [BYTES_PER_WORD-1:0] ram_we_q, ram_we_d;
  logic [DI_W-1:0]           ram_di_q, ram_di_d;
  logic [7:0]                lane_byte;
  logic                      cmd_fire, rsp_fire;
  logic [ADDR_W-1:0]         addr_inc;

  assign cmd_fire = host.cmd_valid & cmd_ready_q;
  assign rsp_fire = rsp_valid_q & host.rsp_ready;
  assign addr_inc = addr_q + ADDR_W'(1);

  byte_lane_mux #(.BYTES_PER_WORD(BYTES_PER_WORD)) u_lane_mux (
    .word_i (ram_do),
    .lane_i (addr_q[LANE_W-1:0]),
    .byte_o (lane_byte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RESET_STATE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
`ifdef CLEAR_ON_RESET_EN
      ST_CLEAR:    if (clr_q == WADDR_W'(DEPTH-1)) state_d = ST_IDLE;
`else
      ST_CLEAR:    state_d = ST_IDLE;
`endif
      ST_IDLE:     if (cmd_fire && !host.cmd_write) state_d = ST_RD_ISSUE;
      ST_RD_ISSUE: state_d = ST_RD_WAIT;
      ST_RD_WAIT:  state_d = ST_RD_HOLD;
      ST_RD_HOLD:  if (rsp_fire) state_d = rsp_last_q ? ST_IDLE : ST_RD_ISSUE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // RAM port values are computed one cycle ahead so the port itself is a register.
  always_comb begin
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_last_d  = rsp_last_q;
    ram_en_d    = 1'b0;
    ram_we_d    = '0;
    ram_addr_d  = ram_addr_q;
    ram_di_d    = ram_di_q;
    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
`ifdef CLEAR_ON_RESET_EN
    clr_d       = clr_q;
`endif
    case (state_q)
`ifdef CLEAR_ON_RESET_EN
      ST_CLEAR: begin
        ram_en_d   = 1'b1;
        ram_we_d   = '1;
        ram_addr_d = clr_q;
        ram_di_d   = '0;
        clr_d      = clr_q + WADDR_W'(1);
      end
`endif
      ST_IDLE: begin
        if (cmd_fire) begin
          ram_en_d   = 1'b1;
          ram_addr_d = host.cmd_addr[ADDR_W-1:LANE_W];
          if (host.cmd_write) begin
            ram_we_d = BYTES_PER_WORD'(1) << host.cmd_addr[LANE_W-1:0];
            ram_di_d = DI_W'(replicate_byte(host.cmd_wdata));
          end else begin
            addr_d = host.cmd_addr;
            cnt_d  = host.cmd_len;
          end
        end
      end
      ST_RD_WAIT: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = lane_byte;
        rsp_last_d  = (cnt_q == '0);
      end
      ST_RD_HOLD: begin
        if (rsp_fire) begin
          rsp_valid_d = 1'b0;
          if (!rsp_last_q) begin
            addr_d     = addr_inc;
            cnt_d      = cnt_q - LEN_W'(1);
            ram_en_d   = 1'b1;
            ram_addr_d = addr_inc[ADDR_W-1:LANE_W];
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_we_q    <= '0;
      ram_di_q    <= '0;
    end else begin
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
      ram_en_q    <= ram_en_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_di_q    <= ram_di_d;
    end
  end

`ifdef CLEAR_ON_RESET_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) clr_q <= '0;
    else        clr_q <= clr_d;
  end
`endif

  assign host.cmd_ready = cmd_ready_q;
  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_data  = rsp_data_q;
  assign host.rsp_last  = rsp_last_q;
  assign busy           = busy_q;
  assign ram_en         = ram_en_q;
  assign ram_addr       = ram_addr_q;
  assign ram_we         = ram_we_q;
  assign ram_di         = ram_di_q;

endmodule

// File: tb/tb_byte_ram_ctrl.sv
// Bench for byte_ram_ctrl: behavioural SRAM plus a flat byte-array reference of its contents.
module tb_byte_ram_ctrl;
  localparam int BPW    = 4;
  localparam int DEPTH  = 32;
  localparam int LEN_W  = 4;
  localparam int ADDR_W = 7;
  localparam int NBYTES = BPW * DEPTH;

  logic        clk;
  logic        rst_n;
  logic        busy;
  logic        ram_en;
  logic [4:0]  ram_addr;
  logic [3:0]  ram_we;
  logic [31:0] ram_di;
  logic [31:0] ram_do;

  logic [31:0] ram_mem [DEPTH];
  logic [7:0]  ref_mem [NBYTES];
  int tests = 0;
  int fails = 0;

  byte_ram_ctrl_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) host ();

  byte_ram_ctrl #(.BYTES_PER_WORD(BPW), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .host     (host),
    .busy     (busy),
    .ram_en   (ram_en),
    .ram_addr (ram_addr),
    .ram_we   (ram_we),
    .ram_di   (ram_di),
    .ram_do   (ram_do)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (ram_en) begin
      for (int l = 0; l < BPW; l++)
        if (ram_we[l]) ram_mem[ram_addr][8*l +: 8] <= ram_di[8*l +: 8];
      ram_do <= ram_mem[ram_addr];
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input int a, input logic [7:0] d);
    check("wr_cmd_ready", host.cmd_ready, 1);
    host.cmd_valid = 1'b1;
    host.cmd_write = 1'b1;
    host.cmd_addr  = ADDR_W'(a);
    host.cmd_wdata = d;
    @(posedge clk); #1;
    check("wr_ram_en", ram_en, 1);
    check("wr_ram_addr", ram_addr, a / BPW);
    check("wr_ram_we", ram_we, 1 << (a % BPW));
    check("wr_ram_di", ram_di, d * 32'h0101_0101);
    host.cmd_valid = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic do_read(input int a, input int len, input int stall);
    int cyc;
    int idx;
    logic [7:0] held;
    check("rd_cmd_ready", host.cmd_ready, 1);
    host.cmd_valid = 1'b1;
    host.cmd_write = 1'b0;
    host.cmd_addr  = ADDR_W'(a);
    host.cmd_len   = LEN_W'(len);
    @(posedge clk); #1;
    host.cmd_valid = 1'b0;
    check("rd_issue_en", ram_en, 1);
    check("rd_issue_we", ram_we, 0);
    check("rd_issue_addr", ram_addr, a / BPW);
    check("rd_busy", busy, 1);
    check("rd_cmd_ready_low", host.cmd_ready, 0);
    for (int i = 0; i <= len; i++) begin
      cyc = 0;
      while (host.rsp_valid !== 1'b1 && cyc < 20) begin
        @(posedge clk); #1;
        cyc++;
      end
      idx = (a + i) % NBYTES;
      check("rsp_latency", cyc, 2);
      check("rsp_data", host.rsp_data, ref_mem[idx]);
      check("rsp_last", host.rsp_last, (i == len));
      held = host.rsp_data;
      if (stall > 0) begin
        host.cmd_valid = 1'b1;
        host.cmd_write = 1'b1;
        for (int s = 0; s < stall; s++) begin
          @(posedge clk); #1;
          check("hold_valid", host.rsp_valid, 1);
          check("hold_data", host.rsp_data, held);
          check("hold_last", host.rsp_last, (i == len));
          check("hold_ram_en", ram_en, 0);
          check("hold_cmd_ready", host.cmd_ready, 0);
        end
        host.cmd_valid = 1'b0;
      end
      host.rsp_ready = 1'b1;
      @(posedge clk); #1;
      host.rsp_ready = 1'b0;
      check("rsp_drop", host.rsp_valid, 0);
      check("rd_next_en", ram_en, (i < len));
      if (i < len) check("rd_next_addr", ram_addr, ((a + i + 1) % NBYTES) / BPW);
    end
    check("rd_done_ready", host.cmd_ready, 1);
    check("rd_done_busy", busy, 0);
  endtask

  initial begin
    int a;
    int n;
    host.cmd_valid = 1'b0;
    host.cmd_write = 1'b0;
    host.cmd_addr  = '0;
    host.cmd_wdata = '0;
    host.cmd_len   = '0;
    host.rsp_ready = 1'b0;
    rst_n = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", host.cmd_ready, 0);
    check("rst_busy", busy, 1);
    check("rst_ram_en", ram_en, 0);
    check("rst_rsp_valid", host.rsp_valid, 0);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_cmd_ready", host.cmd_ready, 1);
    check("rel_busy", busy, 0);
    check("rel_ram_en", ram_en, 0);
    check("rel_ram_addr", ram_addr, 0);
    check("rel_ram_we", ram_we, 0);
    check("rel_ram_di", ram_di, 0);
    check("rel_rsp_valid", host.rsp_valid, 0);
    check("rel_rsp_data", host.rsp_data, 0);
    check("rel_rsp_last", host.rsp_last, 0);

    do_write(6, 8'hA5);
    @(posedge clk); #1;
    check("idle_ram_en", ram_en, 0);
    check("idle_ram_we", ram_we, 0);

    for (int i = 0; i < NBYTES; i++) do_write(i, 8'($urandom));

    do_write(0, 8'h11);
    do_write(1, 8'h22);
    do_write(2, 8'h33);
    do_write(3, 8'h44);
    do_read(1, 2, 0);
    check("pre_b1", ref_mem[1], 8'h22);

    do_write(NBYTES - 1, 8'h7E);
    do_read(NBYTES - 1, 1, 0);
    do_read(5, 1, 10);

    for (int k = 0; k < 12; k++) begin
      do_write(int'($urandom_range(NBYTES - 1)), 8'($urandom));
    end
    for (int k = 0; k < 8; k++) begin
      a = int'($urandom_range(NBYTES - 1));
      n = int'($urandom_range(5));
      do_read(a, n, int'($urandom_range(2)));
    end

    host.cmd_valid = 1'b1;
    host.cmd_write = 1'b0;
    host.cmd_addr  = ADDR_W'(9);
    host.cmd_len   = LEN_W'(3);
    @(posedge clk); #1;
    host.cmd_valid = 1'b0;
    check("abort_pre_en", ram_en, 1);
    rst_n = 1'b0;
    #1;
    check("abort_ram_en", ram_en, 0);
    check("abort_rsp_valid", host.rsp_valid, 0);
    check("abort_busy", busy, 1);
    check("abort_cmd_ready", host.cmd_ready, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_rel_ready", host.cmd_ready, 1);

    host.cmd_valid = 1'b1;
    host.cmd_addr  = ADDR_W'(20);
    host.cmd_len   = LEN_W'(2);
    @(posedge clk); #1;
    host.cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort2_valid_pre", host.rsp_valid, 1);
    rst_n = 1'b0;
    #1;
    check("abort2_rsp_valid", host.rsp_valid, 0);
    check("abort2_rsp_data", host.rsp_data, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    do_read(20, 2, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/byte_ram_ctrl.md
# byte_ram_ctrl

Parametrised byte-access controller for a word-wide, synchronous-read SRAM macro with per-byte write enables, sitting between the chip's pin-level host interface and the RAM macro. It converts single-byte write commands and auto-incrementing burst-read commands into RAM port cycles. Read data is returned one byte at a time over a valid/ready response channel. An optional post-reset sweep zeroes the whole array before the host is served.

## Interface
Parameters:
- BYTES_PER_WORD, 4, bytes per RAM word; power of two, ≥2
- DEPTH, 32, RAM words; power of two
- LEN_W, 4, width of burst-length field
- Derived: LANE_W = log2(BYTES_PER_WORD); WADDR_W = log2(DEPTH); ADDR_W = WADDR_W+LANE_W

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when valid&ready
- cmd_write  in  1  1=single-byte write, 0=burst read
- cmd_addr  in  ADDR_W  byte address
- cmd_wdata  in  8  write byte
- cmd_len  in  LEN_W  read burst length minus one (ignored for writes)
- rsp_valid  out  1  read byte available
- rsp_ready  in  1  host takes byte
- rsp_data  out  8  read byte
- rsp_last  out  1  final byte of burst
- busy  out  1  high whenever not in IDLE
- ram_en  out  1  RAM enable
- ram_addr  out  WADDR_W  RAM word address
- ram_we  out  BYTES_PER_WORD  per-byte write enables
- ram_di  out  8*BYTES_PER_WORD  RAM write data
- ram_do  in  8*BYTES_PER_WORD  RAM read data, valid the cycle after a read-enabled edge

## Operation
- All ram_* outputs are registered. Reset values: cmd_ready 0, rsp_valid 0, rsp_data 0, rsp_last 0, busy 1, ram_en 0, ram_addr 0, ram_we 0, ram_di 0.
- States: CLEAR (macro only), IDLE, RD_ISSUE, RD_WAIT, RD_HOLD.
- IDLE: cmd_ready=1, busy=0.
  - Write accept: next cycle ram_en=1, ram_addr=cmd_addr[ADDR_W-1:LANE_W], ram_we one-hot at lane cmd_addr[LANE_W-1:0], ram_di = wdata replicated to all lanes. Stays in IDLE.
  - Read accept: latch address and remaining count = cmd_len; go to RD_ISSUE.
- RD_ISSUE: ram_en=1, ram_we=0, ram_addr=word of current address; go to RD_WAIT.
- RD_WAIT: capture the lane of ram_do selected by the registered lane index into rsp_data; set rsp_valid=1. Set rsp_last=(count==0). Go to RD_HOLD.
- RD_HOLD: hold rsp_* stable until rsp_ready.
  - On handshake with last: rsp_valid→0, go to IDLE.
  - On handshake otherwise: address+1 modulo 2^ADDR_W (wraps from top byte to byte 0), count-1, go to RD_ISSUE.
- ram_en=0 in every cycle without a RAM access.
- rsp_valid is never asserted outside RD_HOLD.
- cmd_ready=0 in all non-IDLE states.
- Reset asserted mid-burst aborts immediately. Outputs take reset values and the pending response is discarded.

## Timing
- Write: accept edge N → ram_we active during cycle N+1. Back-to-back writes at one per cycle.
- Read: accept edge N → ram_en in cycle N+1 → rsp_valid high from cycle N+3.
- Each following byte: handshake edge M → rsp_valid high again from cycle M+3.
- rsp_valid drops in the cycle after any handshake.
- Burst of L=cmd_len+1 bytes with rsp_ready tied high: the first byte is valid at N+3; the burst returns to IDLE (cmd_ready=1) at N+3L+1.

## Configuration
- CLEAR_ON_RESET_EN defined: the reset state is CLEAR.
  - After rst_n deasserts, writes word k=0..DEPTH-1 in consecutive cycles: ram_en=1, ram_we all ones, ram_di=0.
  - busy=1 and cmd_ready=0 throughout; enters IDLE after DEPTH cycles.
  - Reset during CLEAR restarts the sweep at word 0.
- CLEAR_ON_RESET_EN undefined: the reset state is IDLE. cmd_ready rises in the first cycle after reset release, and RAM contents are untouched.

## Structure
- Package byte_ram_pkg: state enum, LANE_W/WADDR_W/ADDR_W derivation functions, and the replicate-byte function.
- One sub-module, byte_lane_mux: selects an 8-bit lane from the RAM word by a registered lane index, parametrised by BYTES_PER_WORD.

## Test plan
- Reset, no macro → cmd_ready=1 at first cycle after release; busy=0; all ram_* zero.
- Write 0xA5 to addr 6 (BPW=4) → cycle after accept: ram_addr=1, ram_we=4'b0100, ram_di=0xA5A5A5A5.
- Preload 0x11,0x22,0x33,0x44 at addrs 0–3; read addr 1, len 2 → bytes 0x22, 0x33, 0x44 in order; rsp_last only on 0x44; first rsp_valid at accept+3.
- Read at top byte addr (DEPTH·BPW−1), len 1 → second byte comes from addr 0 (wrap).
- Hold rsp_ready low 10 cycles in RD_HOLD → rsp_data/rsp_last stable, no ram_en pulses; cmd_valid ignored.
- Assert rst_n mid-burst → rsp_valid, ram_en 0 asynchronously. With CLEAR_ON_RESET_EN: DEPTH zero-writes precede cmd_ready, then a read of any addr returns 0x00.
